add15_arb: RTL
==============

ADD15_ARB -- requirements
Module: add15_arb

Interface
REQ-001 Parameter PRIO_RESET, default 0: requester index favoured by the first arbitration after reset.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 req_valid  input  2  per-requester request valid, bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; a transfer occurs when valid and ready are both high.
REQ-006 req_a0, req_b0, req_a1, req_b1  input  30 each  operands for requester 0 and requester 1.
REQ-007 req_cin  input  2  per-requester carry-in.
REQ-008 req_wide  input  2  per-requester width select: 1 = 30-bit two-pass add, 0 = 15-bit add.
REQ-009 rsp_valid  output  1  result valid.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_sum  output  30  sum.
REQ-013 rsp_cout  output  1  carry-out of the final pass.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The block SHALL time-share one 15-bit prefix adder between two requesters; there is exactly one adder instance.
REQ-016 The FSM SHALL have states IDLE, LO, HI and DONE.
REQ-017 In IDLE: grant = the sole valid requester, or, if both are valid, the one not served last; req_ready[grant] = 1, the other bit = 0; both bits = 0 outside IDLE.
REQ-018 On a transfer, operands, cin, wide and id SHALL be captured into internal registers; the round-robin pointer SHALL update to the accepted index; next state = LO.
REQ-019 The pointer SHALL change only on a transfer.
REQ-020 LO: adder input is operand bits [14:0] with the captured cin; register the sum into result [14:0] and the carry into a carry register; next state = HI if wide, else DONE.
REQ-021 HI: adder input is operand bits [29:15] with cin = the registered LO carry; register the sum into result [29:15] and the carry; next state = DONE.
REQ-022 Narrow ops: operand bits [29:15] are ignored; rsp_sum[29:15] = 0; rsp_cout = LO carry.
REQ-023 DONE: rsp_valid = 1; rsp_id, rsp_sum and rsp_cout SHALL be held stable while rsp_ready = 0; on rsp_ready = 1, next state = IDLE.
REQ-024 Latency from transfer edge T to rsp_valid: narrow = T+2 cycles, wide = T+3 cycles.
REQ-025 No request is accepted in DONE, even when rsp_ready = 1 in that cycle; peak throughput is 1 op per 3 cycles.
REQ-026 req_ready may depend combinationally on req_valid of the other requester; rsp_valid SHALL be registered (state-decoded only).
REQ-027 Sum wraps modulo 2^15 (narrow) or 2^30 (wide); overflow is reported only via rsp_cout.

Reset
REQ-028 Reset assertion SHALL immediately force state = IDLE, rsp_valid = 0, req_ready = 0 (until released), busy = 0, rsp_id = 0, rsp_sum = 0, rsp_cout = 0, and pointer = last-served 1-PRIO_RESET.
REQ-029 Reset mid-operation SHALL abandon the in-flight op with no response produced; the first op after release SHALL be correct.

Structure
REQ-030 State encoding (IDLE, LO, HI, DONE) and widths (slice 15, full 30) SHALL live in the shared FPU package.
REQ-031 The single sub-module is the existing 15-bit prefix adder bk15, instantiated once; all arbitration and sequencing logic is in add15_arb.

Verification
REQ-032 Narrow, requester 0: a=0x00007FFF, b=0x00000001, cin=0 -> at T+2 rsp_sum=0x00000000, rsp_cout=1, rsp_id=0.
REQ-033 Wide, requester 1: a=0x00007FFF, b=0x00000001, cin=0 -> at T+3 rsp_sum=0x00008000, rsp_cout=0, rsp_id=1 (carry crosses passes).
REQ-034 Wide overflow: a=0x3FFFFFFF, b=0x00000001 -> rsp_sum=0x00000000, rsp_cout=1.
REQ-035 Contention with PRIO_RESET=0: both valid continuously from reset, rsp_ready=1 -> grant order 0,1,0,1, transfers exactly 3 cycles apart (narrow).
REQ-036 Backpressure: rsp_ready=0 for 5 cycles in DONE -> outputs stable, req_ready=00, no transfer; rsp_ready=1 -> IDLE next cycle.
REQ-037 Reset asserted during HI -> rsp_valid=0 and busy=0 immediately; no response for the abandoned op; next narrow op 3+4, cin=1 -> rsp_sum=8.

Source files
------------

// File: rtl/add15_arb_pkg.sv
// add15_arb_pkg: shared state encoding and datapath widths for the time-shared adder
package add15_arb_pkg;
  localparam int SLICE_W = 15;
  localparam int FULL_W = 30;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
endpackage

// File: rtl/add15_arb_bk15.sv
// bk15: 15-bit parallel-prefix adder with carry-in and carry-out
module bk15
  import add15_arb_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);
  // carry-in folded into bit 0 generate, then log-depth prefix combine; descending i keeps reads on the previous level
  always_comb begin
    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    g = a & b;
    p = a ^ b;
    g[0] = g[0] | (p[0] & cin);
    for (int d = 1; d < SLICE_W; d = d * 2)
      for (int i = SLICE_W - 1; i >= d; i--) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    sum = (a ^ b) ^ {g[SLICE_W-2:0], cin};
    cout = g[SLICE_W-1];
  end
endmodule

// File: rtl/add15_arb.sv
// add15_arb: round-robin arbiter sharing one 15-bit adder between two requesters, 30-bit ops in two passes
module add15_arb
  import add15_arb_pkg::*;
#(
  parameter int PRIO_RESET = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [FULL_W-1:0] req_a0,
  input  logic [FULL_W-1:0] req_b0,
  input  logic [FULL_W-1:0] req_a1,
  input  logic [FULL_W-1:0] req_b1,
  input  logic [1:0]        req_cin,
  input  logic [1:0]        req_wide,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [FULL_W-1:0] rsp_sum,
  output logic              rsp_cout,
  output logic              busy
);
  state_t state, state_n;
  logic grant, xfer;
  logic [FULL_W-1:0] a_q, b_q, sum_q;
  logic cin_q, wide_q, id_q, last_q, carry_q;
  logic [SLICE_W-1:0] add_a, add_b, add_s;
  logic add_ci, add_co;

  bk15 u_add (.a(add_a), .b(add_b), .cin(add_ci), .sum(add_s), .cout(add_co));

  // grant, handshake, next state and adder operand slice selection
  always_comb begin
    grant = &req_valid ? ~last_q : req_valid[1];
    xfer = reset && state == IDLE && |req_valid;
    req_ready = xfer ? (grant ? 2'b10 : 2'b01) : 2'b00;
    state_n = state == IDLE ? (xfer ? LO : IDLE) :
              state == LO   ? (wide_q ? HI : DONE) :
              state == HI   ? DONE : (rsp_ready ? IDLE : DONE);
    add_a = state == HI ? a_q[FULL_W-1:SLICE_W] : a_q[SLICE_W-1:0];
    add_b = state == HI ? b_q[FULL_W-1:SLICE_W] : b_q[SLICE_W-1:0];
    add_ci = state == HI ? carry_q : cin_q;
  end

  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;

  // capture on transfer, then accumulate low and high pass results
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      cin_q <= 1'b0;
      wide_q <= 1'b0;
      id_q <= 1'b0;
      carry_q <= 1'b0;
      last_q <= PRIO_RESET == 0;
    end else if (xfer) begin
      a_q <= grant ? req_a1 : req_a0;
      b_q <= grant ? req_b1 : req_b0;
      cin_q <= req_cin[grant];
      wide_q <= req_wide[grant];
      id_q <= grant;
      last_q <= grant;
      sum_q <= '0;
      carry_q <= 1'b0;
    end else if (state == LO) begin
      sum_q[SLICE_W-1:0] <= add_s;
      carry_q <= add_co;
    end else if (state == HI) begin
      sum_q[FULL_W-1:SLICE_W] <= add_s;
      carry_q <= add_co;
    end

  assign rsp_valid = state == DONE;
  assign busy = state != IDLE;
  assign rsp_id = id_q;
  assign rsp_sum = sum_q;
  assign rsp_cout = carry_q;
endmodule
